text_cursor_ctrl: RTL and testbench
===================================

Name: text_cursor_ctrl

Overview:
- Write-side controller for the 32x4 character RAM behind the VGA text display.
- Takes received UART bytes and decides what to write to the RAM, and where.
- Handles printable characters, cursor wrap, CR/LF/backspace, and a full-screen clear sweep.
- Replaces free-running address counters with a single clk-domain sequencer that has a 1-deep holding register.

Parameters:
COLS, 32, characters per row (power of two)
ROWS, 4, rows on screen (power of two)
XW, 5, column address width (log2 COLS)
YW, 2, row address width (log2 ROWS)
BLANK, 8'h20, code written by clear and backspace
CLEAR_ON_RESET, 1, 1 = run a clear sweep automatically after reset is released

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-low reset
rx_data  input  8  received byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe, clk-synchronous
clr_overrun  input  1  clears the sticky overrun flag
ram_we  output  1  RAM write enable, one cycle per write
ram_wy  output  YW  RAM write row
ram_wx  output  XW  RAM write column
ram_wdata  output  8  RAM write data
cursor_x  output  XW  current cursor column
cursor_y  output  YW  current cursor row
busy  output  1  high while a clear sweep is running
overrun  output  1  sticky: a byte was dropped

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clk edge):
  - ram_we=0, ram_wx=0, ram_wy=0, ram_wdata=0, cursor=(0,0), busy=0, overrun=0, holding register empty, state=IDLE.
  - Reset asserted mid-sweep aborts the sweep immediately.
- States: IDLE, CLEAR.
- IDLE, byte accepted at edge N (source is the holding register if full, otherwise rx_valid): outputs take effect at edge N, i.e. they are visible in cycle N+1.
  - Printable (0x20-0x7E):
    - ram_we=1, address = cursor before advance, ram_wdata = byte.
    - Cursor advances one column. From x=COLS-1 it goes to x=0 with y+1; y wraps from ROWS-1 to 0.
  - 0x0D (CR): x=0, no write.
  - 0x0A (LF): y=y+1 with wrap, x unchanged, no write.
  - 0x08 (BS): cursor steps back one cell; (x=0,y>0) goes to (COLS-1, y-1); (0,0) stays put. BLANK is written at the new position, so ram_we=1 even at (0,0).
  - 0x0C (FF): enter CLEAR, no write for the FF byte itself.
  - Any other byte (including >=0x7F): ignored, no write, cursor unchanged.
  - Throughput: one byte per cycle.
- CLEAR:
  - ram_we=1 for exactly ROWS*COLS consecutive cycles, starting the cycle after FF is accepted.
  - Addresses run row-major, (0,0) to (ROWS-1, COLS-1); ram_wdata=BLANK.
  - busy=1 during exactly those cycles. The cursor is set to (0,0) on entry.
  - After the last write: return to IDLE, busy=0.
- Holding register (1 byte):
  - rx_valid while in CLEAR (including its final cycle) stores the byte if the register is empty. If it is full, the byte is dropped and overrun is set.
  - In IDLE with the register full: the held byte is processed first. A simultaneous rx_valid refills the register, with no overrun.
  - A held FF starts a new sweep.
- overrun: set on a drop, cleared when clr_overrun=1. If both happen in the same cycle, set wins.
- CLEAR_ON_RESET=1: CLEAR is entered on the first edge with reset=1, so the sweep begins one cycle after release.
- No writes occur while reset=0.

Test Plan:
1. CLEAR_ON_RESET=1, release reset → exactly 128 ram_we cycles with BLANK over (0,0)..(3,31), busy high for 128 cycles, then cursor=(0,0).
2. Send 'A' (0x41) 33 times, one per cycle → writes at (0,0)..(0,31) then (1,0); final cursor=(1,1). From cursor (3,31), 'B' writes (3,31) and wraps to (0,0).
3. Cursor (2,5): send 0x0D → (2,0), no write. Send 0x0A at (3,0) → (0,0). Send 0x08 at (1,0) → BLANK written at (0,31), cursor=(0,31). Send 0x08 at (0,0) → BLANK written at (0,0).
4. Send 0x0C, then 'Z' during the sweep → 'Z' written at (0,0) the cycle after the last clear write, cursor=(0,1), overrun=0. A second byte during the same sweep is dropped and sets overrun=1; clr_overrun then clears it.
5. Reset pulsed low in sweep cycle 40 → ram_we=0 immediately and state IDLE. The sweep restarts only if CLEAR_ON_RESET=1.
6. Send 0x07, 0x7F, 0x1B → no ram_we, cursor unchanged.

Source files
------------

// File: rtl/text_cursor_ctrl.sv
// Write-side sequencer for the text-mode character RAM: turns received UART
// bytes into RAM writes, tracks the cursor and runs the full-screen clear sweep.
module text_cursor_ctrl #(
    parameter int         COLS           = 32,
    parameter int         ROWS           = 4,
    parameter int         XW             = 5,
    parameter int         YW             = 2,
    parameter logic [7:0] BLANK          = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          clr_overrun,
    output logic          ram_we,
    output logic [YW-1:0] ram_wy,
    output logic [XW-1:0] ram_wx,
    output logic [7:0]    ram_wdata,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          busy,
    output logic          overrun
);
    localparam int            AW   = XW + YW;
    localparam logic [AW-1:0] LAST = AW'(ROWS * COLS - 1);
    localparam logic [XW-1:0] XMAX = XW'(COLS - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [YW-1:0] wy_q, wy_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          busy_q, busy_d;
    logic          ovr_q, ovr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          init_q, init_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    hold_q, hold_d;

    logic          proc_vld;
    logic [7:0]    proc_byte;
    logic          start_clear;
    logic          drop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            wy_q        <= '0;
            wx_q        <= '0;
            wdata_q     <= 8'h00;
            cx_q        <= '0;
            cy_q        <= '0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
            init_q      <= CLEAR_ON_RESET;
            hold_full_q <= 1'b0;
            hold_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            wy_q        <= wy_d;
            wx_q        <= wx_d;
            wdata_q     <= wdata_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            cnt_q       <= cnt_d;
            init_q      <= init_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        wy_d        = wy_q;
        wx_d        = wx_q;
        wdata_d     = wdata_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        busy_d      = 1'b0;
        ovr_d       = ovr_q;
        cnt_d       = cnt_q;
        init_d      = 1'b0;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
        proc_vld    = 1'b0;
        proc_byte   = 8'h00;
        start_clear = 1'b0;
        drop        = 1'b0;

        if (state_q == S_CLEAR && cnt_q != LAST) begin
            cnt_d        = cnt_q + AW'(1);
            {wy_d, wx_d} = cnt_q + AW'(1);
            we_d         = 1'b1;
            wdata_d      = BLANK;
            busy_d       = 1'b1;
            if (rx_valid) begin
                if (hold_full_q) begin
                    drop = 1'b1;
                end else begin
                    hold_full_d = 1'b1;
                    hold_d      = rx_data;
                end
            end
        end else begin
            state_d = S_IDLE;
            if (state_q == S_CLEAR || init_q) begin
                // Final sweep cycle (or post-reset start): incoming bytes still
                // follow the sweep rules, but a held byte is consumed now.
                proc_vld    = hold_full_q;
                proc_byte   = hold_q;
                hold_full_d = 1'b0;
                if (rx_valid) begin
                    if (hold_full_q) begin
                        drop = 1'b1;
                    end else begin
                        hold_full_d = 1'b1;
                        hold_d      = rx_data;
                    end
                end
                start_clear = init_q;
            end else if (hold_full_q) begin
                proc_vld    = 1'b1;
                proc_byte   = hold_q;
                hold_full_d = rx_valid;
                if (rx_valid) begin
                    hold_d = rx_data;
                end
            end else begin
                proc_vld  = rx_valid;
                proc_byte = rx_data;
            end

            if (proc_vld) begin
                if (proc_byte >= 8'h20 && proc_byte <= 8'h7E) begin
                    we_d    = 1'b1;
                    wx_d    = cx_q;
                    wy_d    = cy_q;
                    wdata_d = proc_byte;
                    if (cx_q == XMAX) begin
                        cx_d = '0;
                        cy_d = cy_q + YW'(1);
                    end else begin
                        cx_d = cx_q + XW'(1);
                    end
                end else begin
                    case (proc_byte)
                        8'h0D: cx_d = '0;
                        8'h0A: cy_d = cy_q + YW'(1);
                        8'h08: begin
                            if (cx_q != '0) begin
                                cx_d = cx_q - XW'(1);
                            end else if (cy_q != '0) begin
                                cx_d = XMAX;
                                cy_d = cy_q - YW'(1);
                            end
                            we_d    = 1'b1;
                            wx_d    = cx_d;
                            wy_d    = cy_d;
                            wdata_d = BLANK;
                        end
                        8'h0C:   start_clear = 1'b1;
                        default: ;
                    endcase
                end
            end

            if (start_clear) begin
                state_d = S_CLEAR;
                cnt_d   = '0;
                we_d    = 1'b1;
                wx_d    = '0;
                wy_d    = '0;
                wdata_d = BLANK;
                busy_d  = 1'b1;
                cx_d    = '0;
                cy_d    = '0;
            end
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    assign ram_we    = we_q;
    assign ram_wy    = wy_q;
    assign ram_wx    = wx_q;
    assign ram_wdata = wdata_q;
    assign cursor_x  = cx_q;
    assign cursor_y  = cy_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Bench for text_cursor_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a linear-position reference model.
module tb_text_cursor_ctrl;
    localparam int         COLS  = 32;
    localparam int         ROWS  = 4;
    localparam int         XW    = 5;
    localparam int         YW    = 2;
    localparam int         CELLS = COLS * ROWS;
    localparam logic [7:0] BLANK = 8'h20;
    localparam bit         CLR_RST = 1'b1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          clr_overrun = 1'b0;
    logic          ram_we;
    logic [YW-1:0] ram_wy;
    logic [XW-1:0] ram_wx;
    logic [7:0]    ram_wdata;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic          busy;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    text_cursor_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW),
        .BLANK(BLANK), .CLEAR_ON_RESET(CLR_RST)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .clr_overrun(clr_overrun), .ram_we(ram_we), .ram_wy(ram_wy),
        .ram_wx(ram_wx), .ram_wdata(ram_wdata), .cursor_x(cursor_x),
        .cursor_y(cursor_y), .busy(busy), .overrun(overrun)
    );

    // Reference model: cursor and write address as linear cell indices.
    int         m_pos = 0;
    int         m_wpos = 0;
    int         m_wd = 0;
    int         m_sw = -1;
    bit         m_we = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_pend = 1'b0;
    logic [7:0] m_hold[$];

    task automatic model_edge(input bit rst, input bit v, input logic [7:0] d, input bit clr);
        bit         drop;
        bit         have;
        bit         strict;
        bit         start;
        logic [7:0] b;
        if (!rst) begin
            m_we = 1'b0; m_wpos = 0; m_wd = 0; m_pos = 0; m_busy = 1'b0;
            m_ovr = 1'b0; m_hold.delete(); m_sw = -1; m_pend = CLR_RST;
            return;
        end
        drop = 1'b0; have = 1'b0; start = 1'b0; b = 8'h00;
        m_we = 1'b0; m_busy = 1'b0;
        if (m_sw >= 0 && m_sw < CELLS - 1) begin
            m_sw++; m_we = 1'b1; m_wpos = m_sw; m_wd = BLANK; m_busy = 1'b1;
            if (v) begin
                if (m_hold.size() == 0) m_hold.push_back(d);
                else drop = 1'b1;
            end
        end else begin
            strict = (m_sw == CELLS - 1) || m_pend;
            start = m_pend;
            m_sw = -1; m_pend = 1'b0;
            if (m_hold.size() > 0) begin
                b = m_hold.pop_front(); have = 1'b1;
                if (v) begin
                    if (strict) drop = 1'b1;
                    else m_hold.push_back(d);
                end
            end else if (v) begin
                if (strict) m_hold.push_back(d);
                else begin b = d; have = 1'b1; end
            end
            if (have) begin
                if (b >= 8'h20 && b <= 8'h7E) begin
                    m_we = 1'b1; m_wpos = m_pos; m_wd = b; m_pos = (m_pos + 1) % CELLS;
                end else if (b == 8'h0D) begin
                    m_pos = m_pos - (m_pos % COLS);
                end else if (b == 8'h0A) begin
                    m_pos = (m_pos + COLS) % CELLS;
                end else if (b == 8'h08) begin
                    if (m_pos > 0) m_pos--;
                    m_we = 1'b1; m_wpos = m_pos; m_wd = BLANK;
                end else if (b == 8'h0C) begin
                    start = 1'b1;
                end
            end
            if (start) begin
                m_sw = 0; m_we = 1'b1; m_wpos = 0; m_wd = BLANK; m_busy = 1'b1; m_pos = 0;
            end
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
    endtask

    function automatic logic [24:0] exp_vec();
        return {m_we, 2'(m_wpos / COLS), 5'(m_wpos % COLS), 8'(m_wd),
                2'(m_pos / COLS), 5'(m_pos % COLS), m_busy, m_ovr};
    endfunction

    function automatic logic [24:0] act_vec();
        return {ram_we, ram_wy, ram_wx, ram_wdata, cursor_y, cursor_x, busy, overrun};
    endfunction

    task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit clr);
        reset = rst; rx_valid = v; rx_data = d; clr_overrun = clr;
        model_edge(rst, v, d, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'h41, 1'b0);
            if (act_vec() !== 25'h0) begin
                miscompares++;
                $display("FAIL reset c%0d: got %h want 0", i, act_vec());
            end
            vectors++;
        end
    endtask

    task automatic test_clear_on_reset();
        int wr = 0;
        int bz = 0;
        for (int i = 0; i < 132; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            if (ram_we) wr++;
            if (busy) bz++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL por_sweep c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
        if (wr !== 128 || bz !== 128 || {cursor_y, cursor_x} !== 7'd0) begin
            miscompares++;
            $display("FAIL por_count: writes %0d busy %0d cur %h want 128 128 0", wr, bz, {cursor_y, cursor_x});
        end
        vectors++;
    endtask

    task automatic test_printable();
        for (int i = 0; i < 33; i++) begin
            step(1'b1, 1'b1, 8'h41, 1'b0);
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL print_A c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
        if (cursor_y !== 2'd1 || cursor_x !== 5'd1 || ram_wy !== 2'd1 || ram_wx !== 5'd0) begin
            miscompares++;
            $display("FAIL print_33: cur (%0d,%0d) last wr (%0d,%0d) want (1,1) (1,0)", cursor_y, cursor_x, ram_wy, ram_wx);
        end
        vectors++;
        step(1'b1, 1'b1, 8'h0A, 1'b0);
        step(1'b1, 1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b1, 8'h63, 1'b0);
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL print_c c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
        step(1'b1, 1'b1, 8'h42, 1'b0);
        if (ram_we !== 1'b1 || ram_wy !== 2'd3 || ram_wx !== 5'd31 || ram_wdata !== 8'h42 ||
            {cursor_y, cursor_x} !== 7'd0) begin
            miscompares++;
            $display("FAIL print_wrap: got %h want we=1 (3,31) 42 cur 0", act_vec());
        end
        vectors++;
    endtask

    task automatic test_controls();
        logic [7:0] seq [16] = '{8'h0A, 8'h0A, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h0D,
                                 8'h0A, 8'h0A, 8'h0A, 8'h08, 8'h0D, 8'h08, 8'h08, 8'h0D};
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, seq[i], 1'b0);
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL ctrl c%0d byte %h: got %h want %h", i, seq[i], act_vec(), exp_vec());
            end
            vectors++;
            if (i == 11 && (ram_we !== 1'b1 || ram_wy !== 2'd0 || ram_wx !== 5'd31 ||
                            ram_wdata !== BLANK || cursor_x !== 5'd31 || cursor_y !== 2'd0)) begin
                miscompares++;
                $display("FAIL bs_rowwrap: got %h want blank at (0,31)", act_vec());
            end
            if (i == 13 && (ram_we !== 1'b1 || {ram_wy, ram_wx} !== 7'd0 || ram_wdata !== BLANK ||
                            {cursor_y, cursor_x} !== 7'd0)) begin
                miscompares++;
                $display("FAIL bs_origin: got %h want blank at (0,0)", act_vec());
            end
        end
        vectors += 2;
    endtask

    task automatic test_sweep_hold();
        int zc = -1;
        int lb = -1;
        step(1'b1, 1'b1, 8'h0C, 1'b0);
        for (int i = 1; i < 136; i++) begin
            step(1'b1, i == 10, 8'h5A, 1'b0);
            if (busy) lb = i;
            if (ram_we && ram_wdata === 8'h5A) zc = i;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sweep_z c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
        if (zc !== lb + 1 || cursor_x !== 5'd1 || cursor_y !== 2'd0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL held_z: zcyc %0d lastbusy %0d cur (%0d,%0d) ovr %b want zcyc=lastbusy+1 (0,1) 0",
                     zc, lb, cursor_y, cursor_x, overrun);
        end
        vectors++;
        step(1'b1, 1'b1, 8'h0C, 1'b0);
        for (int i = 1; i < 136; i++) begin
            step(1'b1, i == 5 || i == 7, (i == 5) ? 8'h51 : 8'h52, 1'b0);
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL sweep_drop c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        vectors++;
        step(1'b1, 1'b0, 8'h00, 1'b1);
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clr: got %b want 0", overrun);
        end
        vectors++;
    endtask

    task automatic test_reset_mid_sweep();
        int wr = 0;
        step(1'b1, 1'b1, 8'h0C, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
        if (ram_we !== 1'b1 || ram_wy !== 2'd1 || ram_wx !== 5'd8) begin
            miscompares++;
            $display("FAIL sweep_40: got %h want write at (1,8)", act_vec());
        end
        vectors++;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        if (ram_we !== 1'b0 || busy !== 1'b0 || act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL abort: got %h want %h", act_vec(), exp_vec());
        end
        vectors++;
        for (int i = 0; i < 132; i++) begin
            step(1'b1, 1'b0, 8'h00, 1'b0);
            if (ram_we) wr++;
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL restart c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
        if (wr !== 128) begin
            miscompares++;
            $display("FAIL restart_count: got %0d want 128", wr);
        end
        vectors++;
    endtask

    task automatic test_ignored();
        logic [7:0]    bad [3] = '{8'h07, 8'h7F, 8'h1B};
        logic [XW+YW-1:0] cur;
        step(1'b1, 1'b1, 8'h61, 1'b0);
        step(1'b1, 1'b1, 8'h62, 1'b0);
        cur = {cursor_y, cursor_x};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, bad[i], 1'b0);
            if (ram_we !== 1'b0 || {cursor_y, cursor_x} !== cur) begin
                miscompares++;
                $display("FAIL ignore %h: we %b cur %h want 0 %h", bad[i], ram_we, {cursor_y, cursor_x}, cur);
            end
            vectors++;
        end
    endtask

    task automatic test_back_to_back_random();
        bit         v;
        bit         rst;
        logic [7:0] d;
        int         r;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50) d = 8'($urandom_range(32, 126));
            else if (r < 60) d = 8'h0D;
            else if (r < 70) d = 8'h0A;
            else if (r < 82) d = 8'h08;
            else if (r < 85) d = 8'h0C;
            else d = 8'($urandom_range(0, 255));
            v   = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 499) != 0);
            step(rst, v, d, $urandom_range(0, 19) == 0);
            if (act_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            vectors++;
        end
    endtask

    initial begin
        test_reset();
        test_clear_on_reset();
        test_printable();
        test_controls();
        test_sweep_hold();
        test_reset_mid_sweep();
        test_ignored();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
